sys_out_acc_buf: RTL and testbench

// - Accumulating result buffer on the systolic array output side; fed by the sys_out address generator.
// - Each systolic result word arrives with its sys_out address and is summed into that entry.
// - Once every entry has taken GAMMA contributions, the buffer drains entries 0..M-1 in order to the next stage over a valid/ready handshake.

---
 rtl/sys_out_acc_buf.sv | 118 +++++++++++
 tb/tb_sys_out_acc_buf.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sys_out_acc_buf.sv
// sys_out_acc_buf: accumulating systolic output buffer that drains entries 0..M-1 over valid/ready.
// Define SYS_OUT_ACC_SAT_EN for saturating sums; the default build wraps to DATA_W bits.
module sys_out_acc_buf #(
   parameter int FEATURE_BITS = 4,
   parameter int DATA_W       = 16,
   parameter int M            = 9,
   parameter int GAMMA        = 3
) (
   input  logic                    sys_clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [FEATURE_BITS-1:0] in_addr,
   input  logic [DATA_W-1:0]       in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_W-1:0]       out_data,
   output logic [FEATURE_BITS-1:0] out_idx,
   output logic                    done,
   output logic                    err
);
   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, FIN} state_t;
   state_t state;
   logic [DATA_W-1:0] entry [M];
   logic [3:0] hit [M];
   logic wr, addr_ok, all_hit;
   logic [3:0] cur_hit;
   logic [DATA_W-1:0] cur, rd, acc;
   logic [FEATURE_BITS-1:0] rd_idx;
`ifdef SYS_OUT_ACC_SAT_EN
   logic [DATA_W:0] sum;
`endif
   always_comb begin
      wr = state == ACCUM && in_valid && in_ready;
      addr_ok = in_addr < FEATURE_BITS'(M);
      rd_idx = out_valid ? out_idx + FEATURE_BITS'(1) : '0;
      cur = '0;
      cur_hit = '0;
      rd = '0;
      all_hit = 1'b1;
      for (int i = 0; i < M; i++) begin
         if (in_addr == FEATURE_BITS'(i)) begin
            cur = entry[i];
            cur_hit = hit[i];
         end
         if (rd_idx == FEATURE_BITS'(i)) rd = entry[i];
         if (hit[i] != 4'(GAMMA)) all_hit = 1'b0;
      end
`ifdef SYS_OUT_ACC_SAT_EN
      sum = {cur[DATA_W-1], cur} + {in_data[DATA_W-1], in_data};
      // sign bits disagree only when the true sum left the DATA_W range
      acc = (sum[DATA_W] != sum[DATA_W-1]) ?
            (sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}}) :
            sum[DATA_W-1:0];
`else
      acc = cur + in_data;
`endif
   end
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state <= IDLE;
         in_ready <= 1'b0;
         out_valid <= 1'b0;
         out_data <= '0;
         out_idx <= '0;
         done <= 1'b0;
         err <= 1'b0;
         for (int i = 0; i < M; i++) begin
            entry[i] <= '0;
            hit[i] <= '0;
         end
      end else begin
         case (state)
            IDLE, FIN: if (start) begin
               state <= ACCUM;
               in_ready <= 1'b1;
               done <= 1'b0;
               err <= 1'b0;
               for (int i = 0; i < M; i++) begin
                  entry[i] <= '0;
                  hit[i] <= '0;
               end
            end
            ACCUM: begin
               if (wr) begin
                  if (!addr_ok || cur_hit == 4'(GAMMA)) err <= 1'b1;
                  else for (int i = 0; i < M; i++)
                     if (in_addr == FEATURE_BITS'(i)) begin
                        entry[i] <= acc;
                        hit[i] <= hit[i] + 4'd1;
                     end
               end
               if (all_hit) begin
                  state <= DRAIN;
                  in_ready <= 1'b0;
               end
            end
            DRAIN: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  out_idx <= '0;
                  out_data <= rd;
               end else if (out_ready) begin
                  if (out_idx == FEATURE_BITS'(M-1)) begin
                     state <= FIN;
                     out_valid <= 1'b0;
                     done <= 1'b1;
                  end else begin
                     out_idx <= rd_idx;
                     out_data <= rd;
                  end
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_sys_out_acc_buf.sv
// tb_sys_out_acc_buf: directed bench for sys_out_acc_buf with M=9, GAMMA=3, DATA_W=16.
module tb_sys_out_acc_buf;
   logic sys_clk = 0, reset = 1, start = 0, in_valid = 0, out_ready = 0;
   logic [3:0] in_addr = 0;
   logic [15:0] in_data = 0;
   logic in_ready, out_valid, done, err;
   logic [15:0] out_data;
   logic [3:0] out_idx;
   int nvec = 0, nerr = 0;
   logic [15:0] gd [16];
   logic [3:0] gi [16];

   sys_out_acc_buf #(.FEATURE_BITS(4), .DATA_W(16), .M(9), .GAMMA(3)) dut (
      .sys_clk(sys_clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_idx(out_idx), .done(done), .err(err));

   always #5 sys_clk = ~sys_clk;

   task automatic cyc;
      @(posedge sys_clk);
      #1;
   endtask

   task automatic do_start;
      start = 1;
      cyc;
      start = 0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [15:0] d);
      in_valid = 1;
      in_addr = a;
      in_data = d;
      cyc;
      in_valid = 0;
   endtask

   task automatic fill_basic;
      for (int k = 0; k < 27; k++) wr(4'(k % 9), 16'(1 + k / 9));
   endtask

   // captures handshaken words and counts any change of a stalled word
   task automatic collect(input bit alt, input int lim, output int n, output int bad);
      logic [15:0] pd;
      logic [3:0] pi;
      bit stalled;
      n = 0;
      bad = 0;
      stalled = 0;
      pd = 0;
      pi = 0;
      for (int c = 0; c < 100 && n < lim && n < 16 && !done; c++) begin
         if (stalled && (out_valid !== 1'b1 || out_data !== pd || out_idx !== pi)) bad++;
         out_ready = alt ? c[0] : 1'b1;
         stalled = out_valid && !out_ready;
         pd = out_data;
         pi = out_idx;
         if (out_valid && out_ready) begin
            gd[n] = out_data;
            gi[n] = out_idx;
            n++;
         end
         cyc;
      end
      out_ready = 0;
   endtask

   task automatic test_reset;
      reset = 1;
      cyc;
      cyc;
      nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
      nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      nvec++; if (out_data !== 16'h0) begin nerr++; $display("FAIL reset_out_data got %h exp 0000", out_data); end
      nvec++; if (out_idx !== 4'h0) begin nerr++; $display("FAIL reset_out_idx got %0d exp 0", out_idx); end
      nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done got %b exp 0", done); end
      nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL reset_err got %b exp 0", err); end
      reset = 0;
      cyc;
   endtask

   task automatic test_basic;
      int n, bad;
      do_start;
      nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL basic_in_ready got %b exp 1", in_ready); end
      fill_basic;
      collect(0, 99, n, bad);
      nvec++; if (n !== 9) begin nerr++; $display("FAIL basic_count got %0d exp 9", n); end
      for (int i = 0; i < n; i++) begin
         nvec++; if (gi[i] !== 4'(i) || gd[i] !== 16'd6) begin nerr++; $display("FAIL basic_word%0d got idx %0d data %0d exp idx %0d data 6", i, gi[i], gd[i], i); end
      end
      nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL basic_done got %b exp 1", done); end
      nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL basic_err got %b exp 0", err); end
      nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL basic_out_valid_after got %b exp 0", out_valid); end
   endtask

   task automatic test_backpressure;
      int n, bad;
      do_start;
      nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL bp_done_cleared got %b exp 0", done); end
      fill_basic;
      collect(1, 99, n, bad);
      nvec++; if (n !== 9) begin nerr++; $display("FAIL bp_count got %0d exp 9", n); end
      nvec++; if (bad !== 0) begin nerr++; $display("FAIL bp_hold got %0d changes exp 0", bad); end
      for (int i = 0; i < n; i++) begin
         nvec++; if (gi[i] !== 4'(i) || gd[i] !== 16'd6) begin nerr++; $display("FAIL bp_word%0d got idx %0d data %0d exp idx %0d data 6", i, gi[i], gd[i], i); end
      end
      nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL bp_done got %b exp 1", done); end
   endtask

   task automatic test_errors;
      int n, bad;
      do_start;
      wr(4'd9, 16'd5);
      nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL err_addr9 got %b exp 1", err); end
      wr(4'd2, 16'd1);
      wr(4'd2, 16'd2);
      wr(4'd2, 16'd3);
      wr(4'd2, 16'd100);
      nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL err_stay_accum got in_ready %b exp 1", in_ready); end
      for (int k = 0; k < 27; k++) if (k % 9 != 2) wr(4'(k % 9), 16'(1 + k / 9));
      collect(0, 99, n, bad);
      nvec++; if (n !== 9) begin nerr++; $display("FAIL err_count got %0d exp 9", n); end
      for (int i = 0; i < n; i++) begin
         nvec++; if (gi[i] !== 4'(i) || gd[i] !== 16'd6) begin nerr++; $display("FAIL err_word%0d got idx %0d data %0d exp idx %0d data 6", i, gi[i], gd[i], i); end
      end
      nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL err_sticky got %b exp 1", err); end
   endtask

   task automatic test_overflow;
      int n, bad;
      logic [15:0] exp0;
`ifdef SYS_OUT_ACC_SAT_EN
      exp0 = 16'h7FFF;
`else
      exp0 = 16'h2000;
`endif
      do_start;
      for (int k = 0; k < 3; k++) wr(4'd0, 16'h6000);
      for (int k = 0; k < 24; k++) wr(4'(1 + k % 8), 16'd1);
      collect(0, 99, n, bad);
      nvec++; if (n !== 9) begin nerr++; $display("FAIL ovf_count got %0d exp 9", n); end
      nvec++; if (gd[0] !== exp0) begin nerr++; $display("FAIL ovf_idx0 got %h exp %h", gd[0], exp0); end
      nvec++; if (gd[8] !== 16'd3) begin nerr++; $display("FAIL ovf_idx8 got %0d exp 3", gd[8]); end
   endtask

   task automatic test_reset_mid_drain;
      int n, bad;
      do_start;
      fill_basic;
      collect(0, 5, n, bad);
      nvec++; if (n !== 5 || gi[4] !== 4'd4) begin nerr++; $display("FAIL rst_partial got n %0d idx %0d exp n 5 idx 4", n, gi[4]); end
      reset = 1;
      cyc;
      reset = 0;
      nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
      nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL rst_done got %b exp 0", done); end
      nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL rst_err got %b exp 0", err); end
      nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
      do_start;
      fill_basic;
      collect(0, 99, n, bad);
      nvec++; if (n !== 9) begin nerr++; $display("FAIL rst_rerun_count got %0d exp 9", n); end
      for (int i = 0; i < n; i++) begin
         nvec++; if (gi[i] !== 4'(i) || gd[i] !== 16'd6) begin nerr++; $display("FAIL rst_word%0d got idx %0d data %0d exp idx %0d data 6", i, gi[i], gd[i], i); end
      end
      nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL rst_rerun_done got %b exp 1", done); end
   endtask

   task automatic test_back_to_back;
      int n, bad;
      do_start;
      wr(4'd5, 16'd10);
      wr(4'd5, 16'd20);
      wr(4'd5, 16'd30);
      for (int k = 0; k < 27; k++) if (k % 9 != 5) wr(4'(k % 9), 16'(k % 9));
      collect(0, 99, n, bad);
      nvec++; if (n !== 9) begin nerr++; $display("FAIL b2b_count got %0d exp 9", n); end
      for (int i = 0; i < n; i++) begin
         nvec++; if (gd[i] !== ((i == 5) ? 16'd60 : 16'(3 * i))) begin nerr++; $display("FAIL b2b_word%0d got %0d exp %0d", i, gd[i], (i == 5) ? 60 : 3 * i); end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_backpressure;
      test_errors;
      test_overflow;
      test_reset_mid_drain;
      test_back_to_back;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
